// File: rtl/control_unit_if.sv
// Handshake bundle between the control unit and the datapath.
// The control unit takes the master modport; the datapath takes the slave modport.
interface control_unit_if;
    logic [2:0] IR75;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic       Sub;
    logic [1:0] Asel;
    logic       halted;
    logic       waiting;
    logic [3:0] state;

    modport master (
        input  IR75, Aeq0, Apos, enter,
        output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halted, waiting, state
    );

    modport slave (
        output IR75, Aeq0, Apos, enter,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halted, waiting, state
    );
endinterface

// File: rtl/control_unit.sv
// Instruction sequencer for the simple accumulator CPU: FETCH/DECODE/execute FSM
// driving the datapath strobes, with an Enter-key edge detector for INPUT.
module control_unit (
    input  logic           clock,
    input  logic           reset,
    control_unit_if.master bus_io
);

    typedef enum logic [3:0] {
        StStart  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StLoad   = 4'd3,
        StStore  = 4'd4,
        StAdd    = 4'd5,
        StSub    = 4'd6,
        StInput  = 4'd7,
        StJz     = 4'd8,
        StJpos   = 4'd9,
        StHalt   = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   enter_q;
    logic   enter_pulse;

    logic       ir_load, jmp_mux, pc_load, mem_inst, mem_wr, a_load, sub_op;
    logic [1:0] a_sel;
    logic       halted, waiting;

    // enter_q tracks the key every cycle, so a key already held on entry to INPUT is no edge.
    assign enter_pulse = bus_io.enter & ~enter_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StStart;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= bus_io.enter;
        end
    end

    always_comb begin
        state_d  = StStart;
        ir_load  = 1'b0;
        jmp_mux  = 1'b0;
        pc_load  = 1'b0;
        mem_inst = 1'b0;
        mem_wr   = 1'b0;
        a_load   = 1'b0;
        sub_op   = 1'b0;
        a_sel    = 2'b00;
        halted   = 1'b0;
        waiting  = 1'b0;
        unique case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                state_d  = StDecode;
                ir_load  = 1'b1;
                pc_load  = 1'b1;
                mem_inst = 1'b1;
            end
            StDecode: begin
                unique case (bus_io.IR75)
                    3'b000: state_d = StLoad;
                    3'b001: state_d = StStore;
                    3'b010: state_d = StAdd;
                    3'b011: state_d = StSub;
                    3'b100: state_d = StInput;
                    3'b101: state_d = StJz;
                    3'b110: state_d = StJpos;
                    default: state_d = StHalt;
                endcase
            end
            StLoad: begin
                state_d = StFetch;
                a_load  = 1'b1;
                a_sel   = 2'b10;
            end
            StStore: begin
                state_d = StFetch;
                mem_wr  = 1'b1;
            end
            StAdd: begin
                state_d = StFetch;
                a_load  = 1'b1;
            end
            StSub: begin
                state_d = StFetch;
                a_load  = 1'b1;
                sub_op  = 1'b1;
            end
            StInput: begin
                state_d = enter_pulse ? StFetch : StInput;
                a_sel   = 2'b01;
                waiting = 1'b1;
                a_load  = enter_pulse;
            end
            StJz: begin
                state_d = StFetch;
                jmp_mux = 1'b1;
                pc_load = bus_io.Aeq0;
            end
            StJpos: begin
                state_d = StFetch;
                jmp_mux = 1'b1;
                pc_load = bus_io.Apos;
            end
            StHalt: begin
                state_d = StHalt;
                halted  = 1'b1;
            end
            default: state_d = StStart;
        endcase
    end

    assign bus_io.IRload  = ir_load;
    assign bus_io.JMPmux  = jmp_mux;
    assign bus_io.PCload  = pc_load;
    assign bus_io.Meminst = mem_inst;
    assign bus_io.MemWr   = mem_wr;
    assign bus_io.Aload   = a_load;
    assign bus_io.Sub     = sub_op;
    assign bus_io.Asel    = a_sel;
    assign bus_io.halted  = halted;
    assign bus_io.waiting = waiting;
    assign bus_io.state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction sequences then random stimulus,
// checked every cycle against a behavioural model of the instruction cycle.
module tb_control_unit;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    control_unit_if cu_bus ();

    control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus_io(cu_bus.master)
    );

    int   checks = 0;
    int   errors = 0;
    int   m_state;
    logic m_prev;

    // Expected {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Asel,halted,waiting}.
    function automatic logic [10:0] exp_out(int st, logic z, logic p, logic edge_now);
        case (st)
            1:  return 11'b1_0_1_1_0_0_0_00_0_0;
            3:  return 11'b0_0_0_0_0_1_0_10_0_0;
            4:  return 11'b0_0_0_0_1_0_0_00_0_0;
            5:  return 11'b0_0_0_0_0_1_0_00_0_0;
            6:  return 11'b0_0_0_0_0_1_1_00_0_0;
            7:  return {5'b0, edge_now, 1'b0, 2'b01, 2'b01};
            8:  return {2'b01, z, 8'b0};
            9:  return {2'b01, p, 8'b0};
            10: return 11'b0_0_0_0_0_0_0_00_1_0;
            default: return 11'b0;
        endcase
    endfunction

    // Opcode n executes in state n+3; single-cycle executes go back to FETCH.
    function automatic int exp_next(int st, logic [2:0] ir, logic edge_now);
        if (st == 0) return 1;
        if (st == 1) return 2;
        if (st == 2) return 3 + int'(ir);
        if (st == 7) return edge_now ? 1 : 7;
        if (st == 10) return 10;
        if (st >= 3 && st <= 9) return 1;
        return 0;
    endfunction

    task automatic tick(input logic r, input logic [2:0] ir, input logic z, input logic p,
                        input logic e, input string tag);
        logic [10:0] obs;
        logic [10:0] expv;
        logic [3:0]  exp_st;
        logic        edge_now;
        reset        = r;
        cu_bus.IR75  = ir;
        cu_bus.Aeq0  = z;
        cu_bus.Apos  = p;
        cu_bus.enter = e;
        @(negedge clock);
        edge_now = e & ~m_prev;
        expv     = exp_out(m_state, z, p, edge_now);
        exp_st   = 4'(m_state);
        obs = {cu_bus.IRload, cu_bus.JMPmux, cu_bus.PCload, cu_bus.Meminst, cu_bus.MemWr,
               cu_bus.Aload, cu_bus.Sub, cu_bus.Asel, cu_bus.halted, cu_bus.waiting};
        checks++;
        assert (cu_bus.state === exp_st) else begin
            errors++;
            $error("FAIL %s state observed %0d expected %0d", tag, cu_bus.state, exp_st);
        end
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s outputs observed %b expected %b", tag, obs, expv);
        end
        checks++;
        assert (($countones({cu_bus.IRload, cu_bus.MemWr, cu_bus.Aload}) <= 1) === 1'b1) else begin
            errors++;
            $error("FAIL %s exclusive observed %b%b%b expected at most one high", tag,
                   cu_bus.IRload, cu_bus.MemWr, cu_bus.Aload);
        end
        @(posedge clock);
        m_state = r ? 0 : exp_next(m_state, ir, edge_now);
        m_prev  = r ? 1'b0 : e;
        #1;
    endtask

    // Starting in DECODE: decode, execute, fetch.
    task automatic instr(input logic [2:0] ir, input logic z, input logic p, input string tag);
        tick(1'b0, ir, z, p, 1'b0, tag);
        tick(1'b0, ir, z, p, 1'b0, tag);
        tick(1'b0, ir, z, p, 1'b0, tag);
    endtask

    initial begin
        reset        = 1'b1;
        cu_bus.IR75  = 3'b000;
        cu_bus.Aeq0  = 1'b0;
        cu_bus.Apos  = 1'b0;
        cu_bus.enter = 1'b0;
        @(posedge clock);
        #1;
        m_state = 0;
        m_prev  = 1'b0;

        tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "reset_hold");
        for (int i = 0; i < 5; i++) tick(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "load_seq");
        instr(3'b001, 1'b0, 1'b0, "store");
        instr(3'b010, 1'b0, 1'b0, "add");
        instr(3'b011, 1'b0, 1'b0, "sub");
        instr(3'b101, 1'b1, 1'b0, "jz_taken");
        instr(3'b101, 1'b0, 1'b1, "jz_not_taken");
        instr(3'b110, 1'b0, 1'b1, "jpos_taken");
        instr(3'b110, 1'b1, 1'b0, "jpos_not_taken");

        // INPUT with enter held across entry: no edge until it drops and rises.
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, "input_decode");
        for (int i = 0; i < 6; i++) tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, "input_held");
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "input_low");
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, "input_edge");
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, "input_fetch");

        tick(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, "halt_decode");
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "halt_stay");
        end
        tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "halt_reset");
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "after_halt");

        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "to_decode");
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "decode_input");
        tick(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "in_input");
        tick(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, "reset_in_input");
        tick(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, "start_after_input");
        tick(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, "fetch_b");
        tick(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, "decode_load");
        tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "reset_in_load");
        tick(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "start_after_load");

        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 24) == 0), 3'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
